// File: rtl/spi_regfile.sv
// Register-file front end for spislave: decodes a command byte, then a burst of
// auto-incrementing register reads or writes, and supplies the next MISO byte.
module spi_regfile #(
    parameter int          NREGS    = 8,
    parameter int          LOGNREGS = 3,
    parameter logic [7:0]  ID       = 8'h5A
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ss,
    input  logic [7:0]            rxdata,
    input  logic                  rxready,
    output logic [7:0]            txdata,
    input  logic [7:0]            status,
    output logic [8*NREGS-1:0]    regs,
    output logic                  wr_stb,
    output logic [LOGNREGS-1:0]   wr_addr,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic [LOGNREGS-1:0] ADDR_ONE = {{(LOGNREGS-1){1'b0}}, 1'b1};

    state_t               r_state;
    logic                 r_ss_meta;
    logic                 r_ss_sync;
    logic                 r_armed;
    logic                 r_mode;
    logic [LOGNREGS-1:0]  r_addr;
    logic [7:0]           r_regs [NREGS];

    logic                 w_selected;
    logic [LOGNREGS-1:0]  w_cmd_addr;
    logic [LOGNREGS-1:0]  w_next_addr;
    logic [7:0]           w_cmd_value;
    logic [7:0]           w_next_value;

    assign w_selected  = ~r_ss_sync;
    assign w_cmd_addr  = rxdata[LOGNREGS-1:0];
    assign w_next_addr = r_addr + ADDR_ONE;
    assign dbg_state   = r_state;

    // Address 0 reads back the live status byte; other addresses read the register bank.
    always_comb begin
        w_cmd_value  = (w_cmd_addr == '0)  ? status : r_regs[w_cmd_addr];
        w_next_value = (w_next_addr == '0) ? status : r_regs[w_next_addr];
    end

    always_comb begin
        regs = '0;
        for (int i = 1; i < NREGS; i++) begin
            regs[8*i +: 8] = r_regs[i];
        end
    end

    // Synchroniser resets to "selected" so a transaction interrupted by reset stays
    // locked out (r_armed=0) until SS has been seen high again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ss_meta <= 1'b0;
            r_ss_sync <= 1'b0;
            r_armed   <= 1'b0;
        end else begin
            r_ss_meta <= ss;
            r_ss_sync <= r_ss_meta;
            if (!w_selected) begin
                r_armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            txdata  <= ID;
            r_mode  <= 1'b0;
            r_addr  <= '0;
            wr_stb  <= 1'b0;
            wr_addr <= '0;
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else begin
            wr_stb <= 1'b0;
            if (!w_selected) begin
                // Deselect has priority over any byte arriving in the same cycle.
                r_state <= ST_IDLE;
                txdata  <= ID;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        txdata <= ID;
                        if (r_armed) begin
                            r_state <= ST_CMD;
                        end
                    end
                    ST_CMD: begin
                        if (rxready) begin
                            r_mode  <= rxdata[7];
                            r_addr  <= w_cmd_addr;
                            txdata  <= rxdata[7] ? 8'h00 : w_cmd_value;
                            r_state <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (rxready) begin
                            if (r_mode) begin
                                txdata <= 8'h00;
                                if (r_addr != '0) begin
                                    r_regs[r_addr] <= rxdata;
                                    wr_stb         <= 1'b1;
                                    wr_addr        <= r_addr;
                                end
                            end else begin
                                txdata <= w_next_value;
                            end
                            r_addr <= w_next_addr;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        txdata  <= ID;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_regfile.sv
// Directed bench for spi_regfile: drives rxdata/rxready and ss directly in place of
// spislave and checks MISO bytes, write strobes and register contents.
module tb_spi_regfile;

    logic        clk;
    logic        rst;
    logic        ss;
    logic [7:0]  rxdata;
    logic        rxready;
    logic [7:0]  txdata;
    logic [7:0]  status;
    logic [63:0] regs;
    logic        wr_stb;
    logic [2:0]  wr_addr;
    logic [1:0]  dbg_state;

    int n_checks;
    int n_fail;

    spi_regfile #(.NREGS(8), .LOGNREGS(3), .ID(8'h5A)) dut (
        .clk       (clk),
        .rst       (rst),
        .ss        (ss),
        .rxdata    (rxdata),
        .rxready   (rxready),
        .txdata    (txdata),
        .status    (status),
        .regs      (regs),
        .wr_stb    (wr_stb),
        .wr_addr   (wr_addr),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] get_reg(input int i);
        return regs[8*i +: 8];
    endfunction

    task automatic select_dut();
        @(negedge clk);
        ss = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic deselect_dut();
        @(negedge clk);
        ss = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    // miso: byte the master would receive during this byte; stb/waddr: one clk after rxready.
    task automatic xfer(input logic [7:0] mosi, output logic [7:0] miso,
                        output logic stb, output logic [2:0] waddr);
        @(negedge clk);
        miso    = txdata;
        rxdata  = mosi;
        rxready = 1'b1;
        @(posedge clk);
        #1;
        stb     = wr_stb;
        waddr   = wr_addr;
        rxready = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] m;
        logic s;
        logic [2:0] a;
        rst = 1'b1; ss = 1'b1; rxdata = 8'h00; rxready = 1'b0; status = 8'h00;
        #3;
        n_checks++; if (txdata !== 8'h5A) begin n_fail++; $display("FAIL reset_txdata: got %h want 5a", txdata); end
        n_checks++; if (regs !== 64'h0) begin n_fail++; $display("FAIL reset_regs: got %h want 0", regs); end
        n_checks++; if (wr_stb !== 1'b0) begin n_fail++; $display("FAIL reset_wr_stb: got %b want 0", wr_stb); end
        n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        // Reset arriving mid-clock while a strobe is high must clear everything at once.
        select_dut();
        xfer(8'h85, m, s, a);
        @(negedge clk);
        rxdata = 8'hAB; rxready = 1'b1;
        @(posedge clk);
        #1;
        rxready = 1'b0;
        n_checks++; if (wr_stb !== 1'b1) begin n_fail++; $display("FAIL pre_reset_stb: got %b want 1", wr_stb); end
        n_checks++; if (get_reg(5) !== 8'hAB) begin n_fail++; $display("FAIL pre_reset_reg5: got %h want ab", get_reg(5)); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (wr_stb !== 1'b0) begin n_fail++; $display("FAIL async_reset_stb: got %b want 0", wr_stb); end
        n_checks++; if (regs !== 64'h0) begin n_fail++; $display("FAIL async_reset_regs: got %h want 0", regs); end
        n_checks++; if (txdata !== 8'h5A) begin n_fail++; $display("FAIL async_reset_txdata: got %h want 5a", txdata); end
        @(negedge clk);
        rst = 1'b0;
        deselect_dut();
    endtask

    task automatic test_write_burst();
        logic [7:0] m0, m1, m2;
        logic s0, s1, s2;
        logic [2:0] a0, a1, a2;
        select_dut();
        xfer(8'h83, m0, s0, a0);
        xfer(8'h11, m1, s1, a1);
        xfer(8'h22, m2, s2, a2);
        deselect_dut();
        n_checks++; if (m0 !== 8'h5A) begin n_fail++; $display("FAIL burst_miso0: got %h want 5a", m0); end
        n_checks++; if (s0 !== 1'b0) begin n_fail++; $display("FAIL burst_cmd_stb: got %b want 0", s0); end
        n_checks++; if (m1 !== 8'h00) begin n_fail++; $display("FAIL burst_miso1: got %h want 00", m1); end
        n_checks++; if (s1 !== 1'b1 || a1 !== 3'd3) begin n_fail++; $display("FAIL burst_wr1: got stb=%b addr=%0d want stb=1 addr=3", s1, a1); end
        n_checks++; if (m2 !== 8'h00) begin n_fail++; $display("FAIL burst_miso2: got %h want 00", m2); end
        n_checks++; if (s2 !== 1'b1 || a2 !== 3'd4) begin n_fail++; $display("FAIL burst_wr2: got stb=%b addr=%0d want stb=1 addr=4", s2, a2); end
        n_checks++; if (get_reg(3) !== 8'h11) begin n_fail++; $display("FAIL burst_reg3: got %h want 11", get_reg(3)); end
        n_checks++; if (get_reg(4) !== 8'h22) begin n_fail++; $display("FAIL burst_reg4: got %h want 22", get_reg(4)); end
    endtask

    task automatic test_strobe_width();
        logic [7:0] m;
        logic s;
        logic [2:0] a;
        select_dut();
        xfer(8'h85, m, s, a);
        @(negedge clk);
        rxdata = 8'h5B; rxready = 1'b1;
        @(posedge clk);
        #1;
        rxready = 1'b0;
        n_checks++; if (wr_stb !== 1'b1 || get_reg(5) !== 8'h5B) begin n_fail++; $display("FAIL stb_first: got stb=%b reg5=%h want 1 5b", wr_stb, get_reg(5)); end
        @(posedge clk);
        #1;
        n_checks++; if (wr_stb !== 1'b0) begin n_fail++; $display("FAIL stb_second_cycle: got %b want 0", wr_stb); end
        deselect_dut();
    endtask

    task automatic test_read_wrap();
        logic [7:0] m, r0, r1, r2, r3;
        logic s, s_a0, s_a1;
        logic [2:0] a, a_a1;
        select_dut();
        xfer(8'h87, m, s, a);
        xfer(8'h77, m, s, a);
        xfer(8'hEE, m, s_a0, a);
        xfer(8'h01, m, s_a1, a_a1);
        deselect_dut();
        n_checks++; if (s_a0 !== 1'b0) begin n_fail++; $display("FAIL wrap_addr0_stb: got %b want 0", s_a0); end
        n_checks++; if (s_a1 !== 1'b1 || a_a1 !== 3'd1) begin n_fail++; $display("FAIL wrap_wr1: got stb=%b addr=%0d want 1 1", s_a1, a_a1); end
        status = 8'hC3;
        select_dut();
        xfer(8'h07, r0, s, a);
        xfer(8'h00, r1, s, a);
        xfer(8'h00, r2, s, a);
        xfer(8'h00, r3, s, a);
        deselect_dut();
        n_checks++; if (r0 !== 8'h5A) begin n_fail++; $display("FAIL read_miso0: got %h want 5a", r0); end
        n_checks++; if (r1 !== 8'h77) begin n_fail++; $display("FAIL read_miso1: got %h want 77", r1); end
        n_checks++; if (r2 !== 8'hC3) begin n_fail++; $display("FAIL read_miso2: got %h want c3", r2); end
        n_checks++; if (r3 !== 8'h01) begin n_fail++; $display("FAIL read_miso3: got %h want 01", r3); end
    endtask

    task automatic test_write_addr0();
        logic [7:0] m, r0, r1;
        logic s0, s1;
        logic [2:0] a, a1;
        select_dut();
        xfer(8'h80, m, s0, a);
        xfer(8'hFF, m, s0, a);
        xfer(8'h44, m, s1, a1);
        deselect_dut();
        n_checks++; if (s0 !== 1'b0) begin n_fail++; $display("FAIL addr0_stb: got %b want 0", s0); end
        n_checks++; if (s1 !== 1'b1 || a1 !== 3'd1) begin n_fail++; $display("FAIL addr0_next_wr: got stb=%b addr=%0d want 1 1", s1, a1); end
        n_checks++; if (get_reg(1) !== 8'h44) begin n_fail++; $display("FAIL addr0_reg1: got %h want 44", get_reg(1)); end
        n_checks++; if (get_reg(0) !== 8'h00) begin n_fail++; $display("FAIL addr0_slice0: got %h want 00", get_reg(0)); end
        status = 8'h3C;
        select_dut();
        xfer(8'h00, r0, s0, a);
        xfer(8'h00, r1, s0, a);
        deselect_dut();
        n_checks++; if (r0 !== 8'h5A || r1 !== 8'h3C) begin n_fail++; $display("FAIL status_read: got %h %h want 5a 3c", r0, r1); end
    endtask

    task automatic test_deselect();
        logic [7:0] m, r0, r1;
        logic s;
        logic [2:0] a;
        select_dut();
        xfer(8'h82, m, s, a);
        xfer(8'h55, m, s, a);
        n_checks++; if (s !== 1'b1 || a !== 3'd2) begin n_fail++; $display("FAIL desel_wr2: got stb=%b addr=%0d want 1 2", s, a); end
        // Byte completes in the same cycle the synchronised deselect is seen.
        @(negedge clk);
        ss = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rxdata = 8'h99; rxready = 1'b1;
        @(posedge clk);
        #1;
        rxready = 1'b0;
        n_checks++; if (wr_stb !== 1'b0) begin n_fail++; $display("FAIL desel_stb: got %b want 0", wr_stb); end
        n_checks++; if (txdata !== 8'h5A || dbg_state !== 2'd0) begin n_fail++; $display("FAIL desel_idle: got tx=%h st=%0d want 5a 0", txdata, dbg_state); end
        n_checks++; if (get_reg(2) !== 8'h55 || get_reg(3) !== 8'h11) begin n_fail++; $display("FAIL desel_regs: got r2=%h r3=%h want 55 11", get_reg(2), get_reg(3)); end
        repeat (3) @(posedge clk);
        select_dut();
        xfer(8'h02, r0, s, a);
        xfer(8'h00, r1, s, a);
        deselect_dut();
        n_checks++; if (r0 !== 8'h5A || r1 !== 8'h55) begin n_fail++; $display("FAIL desel_readback: got %h %h want 5a 55", r0, r1); end
    endtask

    task automatic test_reset_mid_write();
        logic [7:0] m;
        logic s, s1, s2;
        logic [2:0] a;
        select_dut();
        xfer(8'h84, m, s, a);
        xfer(8'h66, m, s, a);
        n_checks++; if (get_reg(4) !== 8'h66) begin n_fail++; $display("FAIL rmw_reg4: got %h want 66", get_reg(4)); end
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (regs !== 64'h0 || dbg_state !== 2'd0) begin n_fail++; $display("FAIL rmw_reset: got regs=%h st=%0d want 0 0", regs, dbg_state); end
        @(negedge clk);
        rst = 1'b0;
        xfer(8'h11, m, s1, a);
        xfer(8'h22, m, s2, a);
        n_checks++; if (s1 !== 1'b0 || s2 !== 1'b0) begin n_fail++; $display("FAIL rmw_locked_stb: got %b %b want 0 0", s1, s2); end
        n_checks++; if (regs !== 64'h0 || txdata !== 8'h5A) begin n_fail++; $display("FAIL rmw_locked_state: got regs=%h tx=%h want 0 5a", regs, txdata); end
        deselect_dut();
        select_dut();
        xfer(8'h81, m, s, a);
        xfer(8'h12, m, s, a);
        deselect_dut();
        n_checks++; if (s !== 1'b1 || a !== 3'd1 || get_reg(1) !== 8'h12) begin n_fail++; $display("FAIL rmw_recover: got stb=%b addr=%0d r1=%h want 1 1 12", s, a, get_reg(1)); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_write_burst();
        test_strobe_width();
        test_read_wrap();
        test_write_addr0();
        test_deselect();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_regfile.md
# spi_regfile

SPI register-file front end that sits directly downstream of `spislave`. It consumes each received byte (`rxdata`/`rxready`) and supplies the next byte to transmit (`txdata`). It decodes a one-byte command (read/write plus start address) followed by a burst of data bytes with auto-incrementing address. It holds a small bank of 8-bit control registers for the rest of the FPGA and exposes one read-only status byte.

## Interface
Parameters:
- `NREGS`, 8: number of register addresses; must be a power of 2.
- `LOGNREGS`, 3: log2(`NREGS`).
- `ID`, 8'h5A: byte driven on `txdata` while idle; the master sees it as the first MISO byte of every transaction.

Ports:
- `clk`  in  1  system clock (CLK100 domain, same clock as `spislave`).
- `rst`  in  1  reset; asynchronous, active-high.
- `ss`  in  1  raw SPI_SS pin, active-low, unsynchronised.
- `rxdata`  in  8  byte from `spislave`, valid when `rxready`=1.
- `rxready`  in  1  one-cycle pulse per received byte.
- `txdata`  out  8  byte to `spislave`; registered.
- `status`  in  8  read-only value returned at address 0.
- `regs`  out  8*`NREGS`  register contents; reg i is at [8i+7:8i]; slice 0 is always 8'h00.
- `wr_stb`  out  1  one-cycle pulse on each register write.
- `wr_addr`  out  `LOGNREGS`  address of the current write; valid while `wr_stb`=1.

## Operation
- `ss` passes through 2 flops, exactly like `spislave`. `selected` = ~`ss_sync`.
- State machine, states IDLE, CMD, DATA:
  - IDLE: `txdata`=`ID`. Moves to CMD when `selected`.
  - CMD: on `rxready`:
    - `mode` <= `rxdata[7]` (1 = write, 0 = read).
    - `addr` <= `rxdata[LOGNREGS-1:0]`; bits [6:LOGNREGS] are ignored.
    - In read mode, `txdata` <= value(`rxdata[LOGNREGS-1:0]`). In write mode, `txdata` <= 8'h00.
    - Moves to DATA.
  - DATA: on each `rxready`:
    - Write mode: if `addr`≠0, reg[`addr`] <= `rxdata`, `wr_stb`=1, `wr_addr`=`addr`. Writes to address 0 are ignored and produce no strobe. `txdata` <= 8'h00.
    - Read mode: `txdata` <= value(`addr`+1). The received byte is discarded.
    - Both modes: `addr` <= `addr`+1, modulo `NREGS` (wraps from `NREGS`-1 to 0).
- value(0) = `status`, sampled in the update cycle. value(i≠0) = reg[i].
- Deselect: when `selected` falls in any state, go to IDLE on the next clk and set `txdata`=`ID`. A byte in flight is dropped; registers already written keep their values. If `rxready` and deselect occur in the same cycle, deselect wins and no write occurs.
- Reset (async, immediate): state=IDLE, `txdata`=`ID`, all regs=8'h00, `addr`=0, `mode`=0, `wr_stb`=0, `wr_addr`=0.

## Timing
- `txdata` and `wr_stb`/`wr_addr` update on the clk edge following `rxready`, a latency of 1 cycle.
- `spislave` captures `txdata` at the next byte's first SCK rising edge, which comes at least 2 clk after `rxready` given synchroniser latency. This requires an SCK half-period of at least 3 clk.
- `regs` shows a written value 1 clk after the `rxready` that carried it, the same cycle `wr_stb` is high.
- Every byte-N response reflects register state after byte N-1's write has completed. There are no read-during-write hazards.
- `wr_stb` is never high for 2 consecutive cycles.

## Test plan
- Reset: assert `rst` mid-clock → `txdata`=8'h5A, all `regs`=0, `wr_stb`=0 immediately, with no clk edge required.
- Write burst: bytes 0x83, 0x11, 0x22 → reg3=0x11, reg4=0x22; `wr_stb` pulses with `wr_addr`=3 then 4; MISO reads 0x5A, 0x00, 0x00.
- Read with wrap: preload reg7=0x77, reg1=0x01, `status`=0xC3; send 0x07 then 3 dummy bytes → MISO reads 0x5A, 0x77, 0xC3, 0x01.
- Write to address 0: 0x80, 0xFF, 0x44 → no strobe for address 0, reg1=0x44 with `wr_addr`=1; a later read of address 0 returns `status`.
- Deselect mid-burst: write 0x82, 0x55, then raise `ss` after 4 SCKs of the next byte → reg2=0x55, reg3 unchanged, `txdata`=0x5A; the next transaction 0x02, dummy returns 0x5A, 0x55.
- Async reset mid-write: `rst` pulse between data bytes → regs cleared and state IDLE; remaining bytes in that transaction cause no `wr_stb` until `ss` toggles.
